// File: rtl/tcp_buffer_bind_if.sv
// Valid/ready metadata stream; the payload width is set per instance.
interface axis_meta #(
    parameter int unsigned DATA_W = 16
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tcp_buffer_bind.sv
// Buffer-slot binding table: binds, releases and session lookups arbitrated
// through a single FSM so every table write lands before the next request.
module tcp_buffer_bind #(
    parameter int unsigned FAIL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    axis_meta.slave               s_axis_conn_send,
    axis_meta.master              m_axis_conn_recv,
    axis_meta.slave               s_axis_release,
    axis_meta.slave               s_axis_lookup,
    axis_meta.master              m_axis_lookup_rsp,
    output logic [5:0]            bound_cnt,
    output logic [FAIL_CNT_W-1:0] bind_fail_cnt
);
    localparam int unsigned SLOTS  = 32;
    localparam int unsigned ID_W   = 5;
    localparam int unsigned SESS_W = 16;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [2:0] {
        IDLE, REL, BIND_CHK, BIND_RSP, LOOK, LOOK_RSP
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         req_id_q;
    logic [SESS_W-1:0]       req_sess_q;
    logic                    req_en_q;
    logic [SLOTS-1:0]        slot_valid_q;
    logic [SESS_W-1:0]       slot_sess_q [SLOTS];
    logic [CNT_W-1:0]        bound_cnt_q;
    logic [FAIL_CNT_W-1:0]   fail_cnt_q;
    logic                    conn_valid_q;
    logic [ID_W+SESS_W:0]    conn_data_q;
    logic                    lk_valid_q;
    logic [ID_W:0]           lk_data_q;

    logic [SLOTS-1:0]        sess_match_c;
    logic                    bind_ok_c;
    logic                    lk_hit_c;
    logic [ID_W-1:0]         lk_idx_c;
    logic                    rel_acc_c, bind_acc_c, lk_acc_c;

    // Parallel session compare against every valid slot, lowest index wins.
    always_comb begin
        lk_hit_c = 1'b0;
        lk_idx_c = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            sess_match_c[i] = slot_valid_q[i] && (slot_sess_q[i] == req_sess_q);
        end
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (sess_match_c[i]) begin
                lk_hit_c = 1'b1;
                lk_idx_c = ID_W'(i);
            end
        end
        bind_ok_c = !slot_valid_q[req_id_q] && !(|sess_match_c);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: fixed priority release > bind > lookup while idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (s_axis_release.valid)        state_d = REL;
                else if (s_axis_conn_send.valid) state_d = BIND_CHK;
                else if (s_axis_lookup.valid)    state_d = LOOK;
            end
            REL:      state_d = IDLE;
            BIND_CHK: state_d = BIND_RSP;
            BIND_RSP: if (m_axis_conn_recv.ready) state_d = IDLE;
            LOOK:     state_d = LOOK_RSP;
            LOOK_RSP: if (m_axis_lookup_rsp.ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode: only the arbitration winner sees ready, and only in IDLE.
    always_comb begin
        s_axis_release.ready   = 1'b0;
        s_axis_conn_send.ready = 1'b0;
        s_axis_lookup.ready    = 1'b0;
        if (rstn && state_q == IDLE) begin
            s_axis_release.ready   = s_axis_release.valid;
            s_axis_conn_send.ready = !s_axis_release.valid && s_axis_conn_send.valid;
            s_axis_lookup.ready    = !s_axis_release.valid && !s_axis_conn_send.valid
                                     && s_axis_lookup.valid;
        end
    end

    assign rel_acc_c  = s_axis_release.valid   && s_axis_release.ready;
    assign bind_acc_c = s_axis_conn_send.valid && s_axis_conn_send.ready;
    assign lk_acc_c   = s_axis_lookup.valid    && s_axis_lookup.ready;

    // Request capture, table valid bits, counters and response registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_id_q     <= '0;
            req_sess_q   <= '0;
            req_en_q     <= 1'b0;
            slot_valid_q <= '0;
            bound_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            conn_valid_q <= 1'b0;
            conn_data_q  <= '0;
            lk_valid_q   <= 1'b0;
            lk_data_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rel_acc_c) begin
                        req_en_q   <= s_axis_release.data[21];
                        req_id_q   <= s_axis_release.data[20:16];
                        req_sess_q <= s_axis_release.data[15:0];
                    end else if (bind_acc_c) begin
                        req_en_q   <= 1'b0;
                        req_id_q   <= s_axis_conn_send.data[20:16];
                        req_sess_q <= s_axis_conn_send.data[15:0];
                    end else if (lk_acc_c) begin
                        req_en_q   <= 1'b0;
                        req_sess_q <= s_axis_lookup.data[15:0];
                    end
                end
                REL: begin
                    if (req_en_q && slot_valid_q[req_id_q]
                        && slot_sess_q[req_id_q] == req_sess_q) begin
                        slot_valid_q[req_id_q] <= 1'b0;
                        bound_cnt_q            <= bound_cnt_q - CNT_W'(1);
                    end
                end
                BIND_CHK: begin
                    conn_valid_q <= 1'b1;
                    conn_data_q  <= {bind_ok_c, req_id_q, req_sess_q};
                    if (bind_ok_c) begin
                        slot_valid_q[req_id_q] <= 1'b1;
                        bound_cnt_q            <= bound_cnt_q + CNT_W'(1);
                    end else if (fail_cnt_q != '1) begin
                        fail_cnt_q <= fail_cnt_q + FAIL_CNT_W'(1);
                    end
                end
                BIND_RSP: if (m_axis_conn_recv.ready) conn_valid_q <= 1'b0;
                LOOK: begin
                    lk_valid_q <= 1'b1;
                    lk_data_q  <= {lk_hit_c, lk_idx_c};
                end
                LOOK_RSP: if (m_axis_lookup_rsp.ready) lk_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Session storage; contents are meaningless while the slot is invalid.
    always_ff @(posedge clk) begin
        if (state_q == BIND_CHK && bind_ok_c) slot_sess_q[req_id_q] <= req_sess_q;
    end

    assign m_axis_conn_recv.valid  = conn_valid_q;
    assign m_axis_conn_recv.data   = conn_data_q;
    assign m_axis_lookup_rsp.valid = lk_valid_q;
    assign m_axis_lookup_rsp.data  = lk_data_q;
    assign bound_cnt               = bound_cnt_q;
    assign bind_fail_cnt           = fail_cnt_q;
endmodule

// File: tb/tb_tcp_buffer_bind.sv
// Bench for tcp_buffer_bind: directed vector table, corner sequences and a
// randomized phase checked against a map-based model of the binding table.
module tb_tcp_buffer_bind;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [5:0]  bound_cnt;
    logic [15:0] bind_fail_cnt;

    axis_meta #(.DATA_W(21)) conn_send ();
    axis_meta #(.DATA_W(22)) conn_recv ();
    axis_meta #(.DATA_W(22)) rel ();
    axis_meta #(.DATA_W(16)) lk ();
    axis_meta #(.DATA_W(6))  lk_rsp ();

    tcp_buffer_bind #(.FAIL_CNT_W(16)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .s_axis_conn_send (conn_send.slave),
        .m_axis_conn_recv (conn_recv.master),
        .s_axis_release   (rel.slave),
        .s_axis_lookup    (lk.slave),
        .m_axis_lookup_rsp(lk_rsp.master),
        .bound_cnt        (bound_cnt),
        .bind_fail_cnt    (bind_fail_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: slot flags plus a session->slot map.
    bit          mv [32];
    logic [15:0] ms [32];
    int          sess_map [int];
    int          mcnt = 0;
    int          mfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) mv[i] = 1'b0;
        sess_map.delete();
        mcnt = 0;
        mfail = 0;
    endtask

    function automatic logic [21:0] m_bind(input logic [4:0] id, input logic [15:0] s);
        bit ok;
        ok = !mv[id] && !sess_map.exists(int'(s));
        if (ok) begin
            mv[id] = 1'b1;
            ms[id] = s;
            sess_map[int'(s)] = int'(id);
            mcnt++;
        end else if (mfail < 65535) begin
            mfail++;
        end
        return {ok, id, s};
    endfunction

    function automatic void m_rel(input logic en, input logic [4:0] id, input logic [15:0] s);
        if (en && mv[id] && ms[id] == s) begin
            mv[id] = 1'b0;
            sess_map.delete(int'(s));
            mcnt--;
        end
    endfunction

    function automatic logic [5:0] m_look(input logic [15:0] s);
        if (sess_map.exists(int'(s))) return {1'b1, 5'(sess_map[int'(s)])};
        return 6'd0;
    endfunction

    function automatic logic rdy(input int ch);
        case (ch)
            0:       return rel.ready;
            1:       return conn_send.ready;
            default: return lk.ready;
        endcase
    endfunction

    // Entered at posedge+1 with valid already driven; returns at posedge+1
    // of the cycle after acceptance with that valid dropped.
    task automatic wait_ready(input int ch);
        int n = 0;
        #1;
        while (!rdy(ch) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(ch), 32'hFFFF_FFFF);
        @(posedge clk); #1;
        case (ch)
            0:       rel.valid = 1'b0;
            1:       conn_send.valid = 1'b0;
            default: lk.valid = 1'b0;
        endcase
    endtask

    task automatic bind_txn(input logic [4:0] id, input logic [15:0] s, output logic [21:0] rsp);
        logic [21:0] exp;
        int n = 0;
        conn_send.data = {id, s};
        conn_send.valid = 1'b1;
        wait_ready(1);
        exp = m_bind(id, s);
        while (!conn_recv.valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bind_latency", 32'(n), 32'd1);
        rsp = conn_recv.data;
        chk("bind_rsp", 32'(rsp), 32'(exp));
        @(posedge clk); #1;
        chk("bind_cnt", 32'(bound_cnt), 32'(mcnt));
        chk("bind_fail_cnt", 32'(bind_fail_cnt), 32'(mfail));
    endtask

    task automatic rel_txn(input logic en, input logic [4:0] id, input logic [15:0] s);
        rel.data = {en, id, s};
        rel.valid = 1'b1;
        wait_ready(0);
        @(posedge clk); #1;
        m_rel(en, id, s);
        chk("rel_cnt", 32'(bound_cnt), 32'(mcnt));
    endtask

    task automatic look_txn(input logic [15:0] s, output logic [5:0] rsp);
        int n = 0;
        lk.data = s;
        lk.valid = 1'b1;
        wait_ready(2);
        while (!lk_rsp.valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("look_latency", 32'(n), 32'd1);
        rsp = lk_rsp.data;
        chk("look_rsp", 32'(rsp), 32'(m_look(s)));
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          op;       // 0 release, 1 bind, 2 lookup
        logic        en;
        logic [4:0]  id;
        logic [15:0] sess;
        logic [21:0] exp_rsp;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [21:0] brsp;
        logic [5:0]  lrsp;
        logic [21:0] hold;
        int n;

        conn_send.valid = 1'b0; conn_send.data = '0;
        rel.valid = 1'b0;       rel.data = '0;
        lk.valid = 1'b0;        lk.data = '0;
        conn_recv.ready = 1'b1;
        lk_rsp.ready = 1'b1;
        m_reset();

        vecs[0] = '{1, 1'b0, 5'd3, 16'h0042, {1'b1, 5'd3, 16'h0042}, 6'd1};
        vecs[1] = '{2, 1'b0, 5'd0, 16'h0042, 22'({1'b1, 5'd3}), 6'd1};
        vecs[2] = '{1, 1'b0, 5'd3, 16'h0050, {1'b0, 5'd3, 16'h0050}, 6'd1};
        vecs[3] = '{1, 1'b0, 5'd7, 16'h0042, {1'b0, 5'd7, 16'h0042}, 6'd1};
        vecs[4] = '{0, 1'b1, 5'd3, 16'h0099, 22'd0, 6'd1};
        vecs[5] = '{0, 1'b0, 5'd3, 16'h0042, 22'd0, 6'd1};
        vecs[6] = '{2, 1'b0, 5'd0, 16'h0042, 22'({1'b1, 5'd3}), 6'd1};
        vecs[7] = '{0, 1'b1, 5'd3, 16'h0042, 22'd0, 6'd0};
        vecs[8] = '{2, 1'b0, 5'd0, 16'h0042, 22'd0, 6'd0};

        // Reset state: readies stay low even with every request pending.
        repeat (2) @(posedge clk);
        #1;
        conn_send.valid = 1'b1; rel.valid = 1'b1; lk.valid = 1'b1;
        @(negedge clk);
        chk("rst_readies", {29'd0, rel.ready, conn_send.ready, lk.ready}, 32'd0);
        chk("rst_valids", {30'd0, conn_recv.valid, lk_rsp.valid}, 32'd0);
        chk("rst_conn_data", 32'(conn_recv.data), 32'd0);
        chk("rst_lk_data", 32'(lk_rsp.data), 32'd0);
        chk("rst_counts", {10'd0, bound_cnt, bind_fail_cnt}, 32'd0);
        conn_send.valid = 1'b0; rel.valid = 1'b0; lk.valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed vectors from the bring-up scenarios.
        for (int i = 0; i < 9; i++) begin
            case (vecs[i].op)
                0: rel_txn(vecs[i].en, vecs[i].id, vecs[i].sess);
                1: begin
                    bind_txn(vecs[i].id, vecs[i].sess, brsp);
                    chk("vec_bind_rsp", 32'(brsp), 32'(vecs[i].exp_rsp));
                end
                default: begin
                    look_txn(vecs[i].sess, lrsp);
                    chk("vec_look_rsp", 32'(lrsp), 32'(vecs[i].exp_rsp));
                end
            endcase
            chk("vec_cnt", 32'(bound_cnt), 32'(vecs[i].exp_cnt));
        end
        chk("vec_fail_total", 32'(bind_fail_cnt), 32'd2);

        // Release and bind on the same slot in the same cycle.
        bind_txn(5'd5, 16'h0011, brsp);
        rel.data = {1'b1, 5'd5, 16'h0011}; rel.valid = 1'b1;
        conn_send.data = {5'd5, 16'h0022}; conn_send.valid = 1'b1;
        #1;
        chk("simul_rel_ready", 32'(rel.ready), 32'd1);
        chk("simul_bind_ready", 32'(conn_send.ready), 32'd0);
        wait_ready(0);
        m_rel(1'b1, 5'd5, 16'h0011);
        bind_txn(5'd5, 16'h0022, brsp);
        chk("simul_bind_rsp", 32'(brsp), 32'({1'b1, 5'd5, 16'h0022}));

        // Randomized mix against the model, small session space for conflicts.
        for (int k = 0; k < 300; k++) begin
            int op;
            logic [4:0]  id;
            logic [15:0] s;
            op = int'($urandom_range(0, 2));
            id = 5'($urandom_range(0, 31));
            s  = 16'($urandom_range(0, 15));
            case (op)
                0: begin
                    if (mv[id] && $urandom_range(0, 1) == 1) s = ms[id];
                    rel_txn($urandom_range(0, 3) != 0, id, s);
                end
                1:       bind_txn(id, s, brsp);
                default: look_txn(s, lrsp);
            endcase
        end

        // Backpressure on the bind response while a lookup waits.
        conn_recv.ready = 1'b0;
        conn_send.data = {5'd9, 16'hABCD}; conn_send.valid = 1'b1;
        wait_ready(1);
        hold = m_bind(5'd9, 16'hABCD);
        n = 0;
        while (!conn_recv.valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", 32'(n), 32'd1);
        chk("bp_data", 32'(conn_recv.data), 32'(hold));
        lk.data = 16'hABCD; lk.valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", 32'(conn_recv.valid), 32'd1);
            chk("bp_data_stable", 32'(conn_recv.data), 32'(hold));
            chk("bp_no_accept", 32'(lk.ready), 32'd0);
        end
        conn_recv.ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", 32'(conn_recv.valid), 32'd0);
        chk("bp_idle_ready", 32'(lk.ready), 32'd1);
        look_txn(16'hABCD, lrsp);
        chk("bp_cnt", 32'(bound_cnt), 32'(mcnt));

        // Fill every slot, then one more bind must fail.
        for (int i = 0; i < 32; i++) begin
            if (!mv[i]) bind_txn(5'(i), 16'h8000 + 16'(i), brsp);
        end
        chk("full_cnt", 32'(bound_cnt), 32'd32);
        bind_txn(5'd0, 16'h9999, brsp);
        chk("full_bind_rsp", 32'(brsp), 32'({1'b0, 5'd0, 16'h9999}));
        chk("full_cnt_after", 32'(bound_cnt), 32'd32);

        // Reset while a bind response is stalled.
        conn_recv.ready = 1'b0;
        conn_send.data = {5'd1, 16'h7777}; conn_send.valid = 1'b1;
        wait_ready(1);
        n = 0;
        while (!conn_recv.valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstmid_valid_before", 32'(conn_recv.valid), 32'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("rstmid_valid", 32'(conn_recv.valid), 32'd0);
        chk("rstmid_data", 32'(conn_recv.data), 32'd0);
        chk("rstmid_cnt", 32'(bound_cnt), 32'd0);
        chk("rstmid_fail", 32'(bind_fail_cnt), 32'd0);
        conn_recv.ready = 1'b1;
        m_reset();
        look_txn(16'hABCD, lrsp);
        chk("rstmid_miss0", 32'(lrsp), 32'd0);
        look_txn(16'h8000, lrsp);
        chk("rstmid_miss1", 32'(lrsp), 32'd0);
        look_txn(16'h801F, lrsp);
        chk("rstmid_miss2", 32'(lrsp), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tcp_buffer_bind.md
# tcp_buffer_bind

Binding table between the TCP control register block and the GPU receive datapath. It accepts connection-bind requests carrying {buffer_id, session_id} and returns a bind status. It also accepts release requests that free a buffer slot, and answers session→buffer lookups from the receive path. It holds 32 buffer slots, each mapping one 5-bit buffer_id to at most one 16-bit session_id.

## Interface
- FAIL_CNT_W, 16, width of the saturating bind-failure counter
- clk  in  1  single clock for all logic
- rstn  in  1  synchronous, active-low reset
- s_axis_conn_send  axis_meta.slave  21  bind request: data[20:16] buffer_id, data[15:0] session_id
- m_axis_conn_recv  axis_meta.master  22  bind status: data[21] success, data[20:16] buffer_id, data[15:0] session_id
- s_axis_release  axis_meta.slave  22  release request: data[21] release enable, data[20:16] buffer_id, data[15:0] session_id; data[21]=0 is accepted and discarded
- s_axis_lookup  axis_meta.slave  16  lookup request: session_id
- m_axis_lookup_rsp  axis_meta.master  6  data[5] hit, data[4:0] buffer_id (0 on miss)
- bound_cnt  out  6  number of valid slots, 0..32
- bind_fail_cnt  out  FAIL_CNT_W  saturating count of failed binds

## Operation
- Table state: slot_valid[31:0] and slot_sess[31:0][15:0]. Reset clears slot_valid only.
- FSM states: IDLE, REL, BIND_CHK, BIND_RSP, LOOK, LOOK_RSP.
- In IDLE, all three slave readies are high only for the input selected by the arbiter. All readies are low in every other state.
- Arbitration in IDLE uses fixed priority: release > bind > lookup. Exactly one request is accepted per IDLE cycle, and its payload is registered.
- REL:
  - If enable=1, slot_valid[id]=1 and slot_sess[id]==session_id, clear slot_valid[id] and decrement bound_cnt.
  - Otherwise make no change.
  - Go to IDLE. No response is sent.
- BIND_CHK:
  - success = ~slot_valid[id] AND no valid slot already holds session_id (32-way parallel compare).
  - On success, write the slot and increment bound_cnt.
  - On failure, increment bind_fail_cnt, saturating at all-ones.
  - Go to BIND_RSP.
- BIND_RSP: m_axis_conn_recv.valid=1 with {success, id, session}. Hold valid and data stable until ready, then go to IDLE.
- LOOK:
  - Compare session_id against all valid slots; the lowest-index match wins.
  - Register {hit, idx} and go to LOOK_RSP.
- LOOK_RSP: m_axis_lookup_rsp.valid=1. Hold until ready, then go to IDLE.
- Same buffer_id requested by release and bind in the same cycle: the release is taken first. The bind is evaluated afterwards, against the freed slot.
- A lookup issued after a bind or release always sees the updated table, because table writes complete before the FSM returns to IDLE.

## Timing
- Reset values: both master valids = 0, all slave readies = 0, master data = 0, bound_cnt = 0, bind_fail_cnt = 0, state = IDLE. Readies may go high from the first cycle after rstn rises.
- Request accepted in cycle N (valid & ready while in IDLE):
  - Release: table updated at the N+1 edge; IDLE in cycle N+2.
  - Bind: decision and write in cycle N+1; m_axis_conn_recv.valid high from cycle N+2.
  - Lookup: compare in cycle N+1; m_axis_lookup_rsp.valid high from cycle N+2.
- Response ready already high in cycle N+2: the FSM is back in IDLE in cycle N+3, so sustained bind throughput is one request per 3 cycles.
- Backpressure: a master holds valid and data with no change until ready. No new request is accepted meanwhile.
- bound_cnt and bind_fail_cnt update on the same edge as the table write.
- rstn low in any state aborts the operation the same cycle:
  - pending responses are dropped;
  - valid falls at the next edge;
  - the table is emptied.

## Test plan
- Bind after reset: bind {id=3, sess=0x0042} → conn_recv {1,3,0x0042} with valid at N+2; bound_cnt=1; lookup 0x0042 → {hit=1, id=3}.
- Bind conflict: with slot 3 holding 0x0042, bind {3, 0x0050} → {0,3,0x0050}. Bind {7, 0x0042} → {0,7,0x0042}. bind_fail_cnt=2, bound_cnt unchanged.
- Release rules:
  - release {1, 3, 0x0099} (session mismatch) → slot kept;
  - release {0, 3, 0x0042} → discarded;
  - release {1, 3, 0x0042} → bound_cnt=0, and lookup 0x0042 → {0, 0}.
- Simultaneous release {1,5,0x0011} and bind {5,0x0022} with slot 5 bound to 0x0011 → release accepted first, then bind returns {1,5,0x0022}.
- Backpressure: hold conn_recv.ready=0 for 10 cycles → valid and data stable, no request accepted. Assert ready → handshake, IDLE next cycle. Fill all 32 slots → bound_cnt=32, 33rd bind fails.
- Reset mid-BIND_RSP (rstn low 1 cycle) → valid=0 the next cycle, bound_cnt=0, every lookup misses.
